mc_control_fsm: RTL and testbench

Multi-cycle successor to the single-cycle combinational control decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the datapath enables for each state. It handshakes with a shared instruction/data memory (`mem_req`/`mem_ready`), supports BEQ-style branching, a resumable HALT, and a sticky illegal-opcode trap. It sits between the instruction register and the datapath, replacing the combinational decoder in the multi-cycle core.

---
 rtl/ctrl_pkg.sv | 37 +++
 rtl/ctrl_opcode_decode.sv | 22 ++
 rtl/mc_control_fsm.sv | 220 ++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control definitions: opcodes, FSM states, instruction classes and ALU op codes.
// Used by both the multi-cycle controller and the single-cycle decoder path.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_HALT   = 7'b1111111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    IC_R,
    IC_I,
    IC_LOAD,
    IC_STORE,
    IC_BRANCH,
    IC_HALT,
    IC_ILLEGAL
  } iclass_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_RF  = 2'b10;
  localparam logic [1:0] ALU_IF  = 2'b11;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode classifier, zero latency, no flow control.
// Anything not recognised is reported as IC_ILLEGAL.
module ctrl_opcode_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    iclass
);

  always_comb begin
    case (opcode)
      OP_R:      iclass = IC_R;
      OP_I:      iclass = IC_I;
      OP_LOAD:   iclass = IC_LOAD;
      OP_STORE:  iclass = IC_STORE;
      OP_BRANCH: iclass = IC_BRANCH;
      OP_HALT:   iclass = IC_HALT;
      default:   iclass = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller; outputs are combinational from state/op_q, stalls on mem_ready.
// MC_CTRL_TIMEOUT_EN adds a bounded memory wait that traps with `timeout` after MEM_TIMEOUT un-acked cycles.
module mc_control_fsm
  import ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             halted,
  output logic             illegal,
  output logic             timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  // A wait bound below one cycle has no meaningful hardware; nothing is built for it.
  if (MEM_TIMEOUT < 1) begin : g_bad_mem_timeout
  end

  state_t           state_q, state_d;
  logic [6:0]       op_q;
  logic [6:0]       dec_op;
  iclass_t          iclass;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  logic       mem_req_c, mem_read_c, mem_write_c, ir_write_c, pc_write_c;
  logic       branch_c, alu_src_c, mem_to_reg_c, reg_write_c, halted_c;
  logic       illegal_c, timeout_c;
  logic [1:0] alu_op_c;

  // DECODE classifies the live opcode; later states classify the latched copy.
  assign dec_op = (state_q == S_DECODE) ? opcode : op_q;

  ctrl_opcode_decode u_decode (
    .opcode (dec_op),
    .iclass (iclass)
  );

`ifdef MC_CTRL_TIMEOUT_EN
  localparam int               WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_q;
  logic              to_q;
  logic              stall;
  logic              to_trap;

  assign stall = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
`endif

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    mem_req_c    = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    branch_c     = 1'b0;
    alu_src_c    = 1'b0;
    alu_op_c     = ALU_ADD;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    halted_c     = 1'b0;
`ifdef MC_CTRL_TIMEOUT_EN
    to_trap      = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        case (iclass)
          IC_HALT: begin
            state_d = S_HALT;
            retire  = 1'b1;
          end
          IC_ILLEGAL: state_d = S_TRAP;
          default:    state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (iclass)
          IC_R: begin
            alu_op_c = ALU_RF;
            state_d  = S_WB;
          end
          IC_I: begin
            alu_op_c  = ALU_IF;
            alu_src_c = 1'b1;
            state_d   = S_WB;
          end
          IC_LOAD, IC_STORE: begin
            alu_src_c = 1'b1;
            state_d   = S_MEM;
          end
          IC_BRANCH: begin
            branch_c   = 1'b1;
            alu_op_c   = ALU_SUB;
            pc_write_c = zero;
            retire     = 1'b1;
            state_d    = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_req_c   = 1'b1;
        alu_src_c   = 1'b1;
        mem_read_c  = (iclass == IC_LOAD);
        mem_write_c = (iclass == IC_STORE);
        if (mem_ready) begin
          if (iclass == IC_LOAD) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = (iclass == IC_LOAD);
        if (iclass == IC_R) begin
          alu_op_c = ALU_RF;
        end else if (iclass == IC_I) begin
          alu_op_c  = ALU_IF;
          alu_src_c = 1'b1;
        end
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted_c = 1'b1;
        if (resume) state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
`ifdef MC_CTRL_TIMEOUT_EN
    // A ready in the final allowed cycle still completes the access.
    if (stall && (wait_q == WAIT_LAST)) begin
      state_d = S_TRAP;
      to_trap = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= 7'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef MC_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
      to_q   <= 1'b0;
    end else begin
      if (state_d != state_q) wait_q <= '0;
      else if (stall)         wait_q <= wait_q + WAIT_W'(1);
      if (to_trap) to_q <= 1'b1;
    end
  end

  assign timeout_c = (state_q == S_TRAP) && to_q;
  assign illegal_c = (state_q == S_TRAP) && !to_q;
`else
  assign timeout_c = 1'b0;
  assign illegal_c = (state_q == S_TRAP);
`endif

  // The reset state is FETCH, so the request must be masked while rst is held.
  assign mem_req    = mem_req_c    & ~rst;
  assign mem_read   = mem_read_c   & ~rst;
  assign mem_write  = mem_write_c  & ~rst;
  assign ir_write   = ir_write_c   & ~rst;
  assign pc_write   = pc_write_c   & ~rst;
  assign branch     = branch_c     & ~rst;
  assign alu_src    = alu_src_c    & ~rst;
  assign alu_op     = alu_op_c     & {2{~rst}};
  assign mem_to_reg = mem_to_reg_c & ~rst;
  assign reg_write  = reg_write_c  & ~rst;
  assign halted     = halted_c     & ~rst;
  assign illegal    = illegal_c    & ~rst;
  assign timeout    = timeout_c    & ~rst;
  assign state      = state_q;
  assign instr_cnt  = cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: each stimulus cycle queues its hand-computed expectation,
// and a negedge monitor pops and compares state, the packed control outputs and instr_cnt.
module tb_mc_control_fsm;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_HLT = 7'b1111111;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  // Field order: req rd wr irw pcw br src op[1:0] m2r rw hlt ill to
  localparam logic [13:0] O_NONE   = 14'b0_0_0_0_0_0_0_00_0_0_0_0_0;
  localparam logic [13:0] O_FW     = 14'b1_1_0_0_0_0_0_00_0_0_0_0_0;
  localparam logic [13:0] O_FA     = 14'b1_1_0_1_1_0_0_00_0_0_0_0_0;
  localparam logic [13:0] O_EX_R   = 14'b0_0_0_0_0_0_0_10_0_0_0_0_0;
  localparam logic [13:0] O_EX_I   = 14'b0_0_0_0_0_0_1_11_0_0_0_0_0;
  localparam logic [13:0] O_EX_LS  = 14'b0_0_0_0_0_0_1_00_0_0_0_0_0;
  localparam logic [13:0] O_BR_T   = 14'b0_0_0_0_1_1_0_01_0_0_0_0_0;
  localparam logic [13:0] O_BR_N   = 14'b0_0_0_0_0_1_0_01_0_0_0_0_0;
  localparam logic [13:0] O_MEM_LD = 14'b1_1_0_0_0_0_1_00_0_0_0_0_0;
  localparam logic [13:0] O_MEM_ST = 14'b1_0_1_0_0_0_1_00_0_0_0_0_0;
  localparam logic [13:0] O_WB_R   = 14'b0_0_0_0_0_0_0_10_0_1_0_0_0;
  localparam logic [13:0] O_WB_I   = 14'b0_0_0_0_0_0_1_11_0_1_0_0_0;
  localparam logic [13:0] O_WB_LD  = 14'b0_0_0_0_0_0_0_00_1_1_0_0_0;
  localparam logic [13:0] O_HLT    = 14'b0_0_0_0_0_0_0_00_0_0_1_0_0;
  localparam logic [13:0] O_ILL    = 14'b0_0_0_0_0_0_0_00_0_0_0_1_0;
  localparam logic [13:0] O_TO     = 14'b0_0_0_0_0_0_0_00_0_0_0_0_1;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [13:0] outs;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        resume = 1'b0;
  logic        mem_req, mem_read, mem_write, ir_write, pc_write, branch, alu_src;
  logic [1:0]  alu_op;
  logic        mem_to_reg, reg_write, halted, illegal, timeout;
  logic [2:0]  state;
  logic [31:0] instr_cnt;
  logic [13:0] obs;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mc_control_fsm #(.CNT_W(32), .MEM_TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .resume     (resume),
    .mem_req    (mem_req),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .branch     (branch),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .halted     (halted),
    .illegal    (illegal),
    .timeout    (timeout),
    .state      (state),
    .instr_cnt  (instr_cnt)
  );

  assign obs = {mem_req, mem_read, mem_write, ir_write, pc_write, branch, alu_src,
                alu_op, mem_to_reg, reg_write, halted, illegal, timeout};

  always #5 clk = ~clk;

  // One stimulus cycle: drive just after the rising edge, queue what this cycle must show.
  task automatic cyc(input logic r, input logic rdy, input logic z, input logic res,
                     input logic [6:0] op, input logic [2:0] es, input logic [13:0] eo,
                     input logic [31:0] ec, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    mem_ready = rdy;
    zero      = z;
    resume    = res;
    opcode    = op;
    e.tag  = tag;
    e.st   = es;
    e.outs = eo;
    e.cnt  = ec;
    exp_q.push_back(e);
  endtask

  task automatic run_r(input logic [31:0] c);
    cyc(0, 1, 0, 0, OP_R, 3'd0, O_FA,   c, "r_fetch");
    cyc(0, 1, 0, 0, OP_R, 3'd1, O_NONE, c, "r_decode");
    cyc(0, 1, 0, 0, OP_R, 3'd2, O_EX_R, c, "r_exec");
    cyc(0, 1, 0, 0, OP_R, 3'd4, O_WB_R, c, "r_wb");
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (state !== e.st || obs !== e.outs || instr_cnt !== e.cnt) begin
          errors++;
          $display("FAIL %s: got state=%0d outs=%b cnt=%0d, want state=%0d outs=%b cnt=%0d",
                   e.tag, state, obs, instr_cnt, e.st, e.outs, e.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got running want finished");
    $fatal(1);
  end

  initial begin : stimulus
    cyc(1, 1, 0, 0, OP_R, 3'd0, O_NONE, 0, "reset_0");
    cyc(1, 1, 0, 0, OP_R, 3'd0, O_NONE, 0, "reset_1");

    run_r(0);

    cyc(0, 1, 0, 0, OP_I, 3'd0, O_FA,   1, "i_fetch");
    cyc(0, 1, 0, 0, OP_I, 3'd1, O_NONE, 1, "i_decode");
    cyc(0, 1, 0, 0, OP_I, 3'd2, O_EX_I, 1, "i_exec");
    cyc(0, 1, 0, 0, OP_I, 3'd4, O_WB_I, 1, "i_wb");

    cyc(0, 1, 0, 0, OP_LD, 3'd0, O_FA,     2, "ld_fetch");
    cyc(0, 1, 0, 0, OP_LD, 3'd1, O_NONE,   2, "ld_decode");
    cyc(0, 1, 0, 0, OP_LD, 3'd2, O_EX_LS,  2, "ld_exec");
    cyc(0, 0, 0, 0, OP_LD, 3'd3, O_MEM_LD, 2, "ld_mem_wait1");
    cyc(0, 0, 0, 0, OP_LD, 3'd3, O_MEM_LD, 2, "ld_mem_wait2");
    cyc(0, 0, 0, 0, OP_LD, 3'd3, O_MEM_LD, 2, "ld_mem_wait3");
    cyc(0, 1, 0, 0, OP_LD, 3'd3, O_MEM_LD, 2, "ld_mem_ack");
    cyc(0, 1, 0, 0, OP_LD, 3'd4, O_WB_LD,  2, "ld_wb");

    cyc(0, 1, 0, 0, OP_ST, 3'd0, O_FA,     3, "st_fetch");
    cyc(0, 1, 0, 0, OP_ST, 3'd1, O_NONE,   3, "st_decode");
    cyc(0, 1, 0, 0, OP_ST, 3'd2, O_EX_LS,  3, "st_exec");
    cyc(0, 1, 0, 0, OP_ST, 3'd3, O_MEM_ST, 3, "st_mem");

    cyc(0, 1, 1, 0, OP_BR, 3'd0, O_FA,   4, "beq_t_fetch");
    cyc(0, 1, 1, 0, OP_BR, 3'd1, O_NONE, 4, "beq_t_decode");
    cyc(0, 1, 1, 0, OP_BR, 3'd2, O_BR_T, 4, "beq_t_exec");

    // resume held high here must not disturb a normal instruction
    cyc(0, 1, 0, 1, OP_BR, 3'd0, O_FA,   5, "beq_n_fetch");
    cyc(0, 1, 0, 1, OP_BR, 3'd1, O_NONE, 5, "beq_n_decode");
    cyc(0, 1, 0, 1, OP_BR, 3'd2, O_BR_N, 5, "beq_n_exec");

    cyc(0, 0, 0, 0, OP_HLT, 3'd0, O_FW,   6, "hlt_fetch_wait1");
    cyc(0, 0, 0, 0, OP_HLT, 3'd0, O_FW,   6, "hlt_fetch_wait2");
    cyc(0, 1, 0, 0, OP_HLT, 3'd0, O_FA,   6, "hlt_fetch");
    cyc(0, 1, 0, 0, OP_HLT, 3'd1, O_NONE, 6, "hlt_decode");
    for (int i = 0; i < 10; i++)
      cyc(0, 1, 0, 0, OP_HLT, 3'd5, O_HLT, 7, "halted_hold");
    cyc(0, 1, 0, 1, OP_HLT, 3'd5, O_HLT, 7, "halt_resume_cycle");

    cyc(0, 1, 0, 0, OP_BAD, 3'd0, O_FA,   7, "after_resume_fetch");
    cyc(0, 1, 0, 0, OP_BAD, 3'd1, O_NONE, 7, "bad_decode");
    for (int i = 0; i < 20; i++)
      cyc(0, 1, 0, (i == 10), OP_BAD, 3'd6, O_ILL, 7, "trap_hold");
    cyc(1, 1, 0, 0, OP_BAD, 3'd0, O_NONE, 0, "trap_reset_0");
    cyc(1, 1, 0, 0, OP_BAD, 3'd0, O_NONE, 0, "trap_reset_1");

`ifdef MC_CTRL_TIMEOUT_EN
    for (int i = 0; i < 8; i++)
      cyc(0, 0, 0, 0, OP_R, 3'd0, O_FW, 0, "to_fetch_wait");
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 0, 1, OP_R, 3'd6, O_TO, 0, "to_trap");
    cyc(1, 0, 0, 0, OP_R, 3'd0, O_NONE, 0, "to_reset");
    for (int i = 0; i < 7; i++)
      cyc(0, 0, 0, 0, OP_R, 3'd0, O_FW, 0, "to_edge_wait");
`else
    for (int i = 0; i < 100; i++)
      cyc(0, 0, 0, 0, OP_R, 3'd0, O_FW, 0, "unbounded_wait");
`endif
    run_r(0);

    cyc(0, 1, 0, 0, OP_ST, 3'd0, O_FA,     1, "abort_fetch");
    cyc(0, 1, 0, 0, OP_ST, 3'd1, O_NONE,   1, "abort_decode");
    cyc(0, 1, 0, 0, OP_ST, 3'd2, O_EX_LS,  1, "abort_exec");
    cyc(0, 0, 0, 0, OP_ST, 3'd3, O_MEM_ST, 1, "abort_mem");
    cyc(1, 1, 0, 0, OP_ST, 3'd0, O_NONE,   0, "abort_reset");
    cyc(0, 1, 0, 0, OP_ST, 3'd0, O_FA,     0, "abort_refetch");

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
